fetch_in_unit: RTL and testbench
================================

// Module: fetch_in_unit
//
// PURPOSE
//   Program-counter register of the RISC-V fetch stage. Each clock it loads the next PC.
//   - Sequential path: pc_4, the current PC + 4, computed outside this block.
//   - Redirect path: alu_in, the branch/jump target from the execute-stage ALU.
//   pc_out drives the instruction-memory address and the external PC+4 adder.
//
// PARAMETERS
//   XLEN      32            width of PC and both next-PC inputs
//   RESET_PC  32'h0000_0000 value loaded into the PC while reset is asserted
//
// PORTS
//   clk            input   1     system clock; all state updates on rising edge
//   rst            input   1     asynchronous reset, active-low (0 = reset)
//   pc_4           input   XLEN  sequential next PC (current PC + 4)
//   alu_in         input   XLEN  redirect target from the ALU
//   pc_sel         input   1     0 = take pc_4, 1 = take alu_in
//   pc_out         output  XLEN  current PC (registered)
//   pc_misaligned  output  1     present only with FETCH_IN_MISALIGN_EN (see CONFIGURATION)
//
// BEHAVIOUR
//   - Reset: while rst==0, pc_out = RESET_PC. This takes effect immediately and does not
//     wait for a clock edge. After rst rises, the first rising clk edge performs a normal load.
//   - Next-PC mux is combinational: next_pc = pc_sel ? alu_in : pc_4.
//   - Register: on each rising clk with rst==1, pc_out <= next_pc.
//     Latency is exactly 1 cycle from the inputs to pc_out. There is no enable or stall;
//     the PC loads every cycle.
//   - Loads are verbatim: no alignment masking, no arithmetic, no wrap handling.
//     A value of 32'hFFFF_FFFC + 4 computed externally arrives as 0 and is loaded as-is.
//   - pc_sel sampled X/Z: the output is unspecified. Simulation must flag it with an assertion.
//   - If rst asserts in the middle of operation, pc_out goes to RESET_PC immediately,
//     independent of clk, pc_sel and the data inputs.
//   - If inputs change while the clock is stable, pc_out does not change (no combinational
//     path from the inputs to pc_out).
//   - pc_out is the only output in the base configuration.
//
// CONFIGURATION
//   FETCH_IN_MISALIGN_EN
//   - Defined: the block adds the registered output pc_misaligned.
//     - It resets to 0.
//     - On each load it is set to (next_pc[1:0] != 2'b00), so it updates with the same
//       1-cycle latency as pc_out.
//     - pc_out is still loaded verbatim; the flag is only reported, not corrected.
//   - Undefined: the pc_misaligned port and its logic do not exist. The port list is exactly
//     clk, rst, pc_4, alu_in, pc_sel, pc_out.
//
// TESTING
//   1. rst=0 for 1 ns at t=0 with the clock running
//      -> pc_out = 32'h0 immediately, before any clk edge.
//   2. rst=1, pc_sel=1, alu_in=32'hAAAA_AAAA, pc_4=32'h3333_3333, 10 ns clock
//      -> after the next rising edge pc_out = 32'hAAAA_AAAA, held for the whole 100 ns.
//   3. Same inputs, pc_sel switched to 0 for 100 ns
//      -> pc_out = 32'h3333_3333 starting at the first rising edge after the switch.
//   4. Change alu_in and pc_4 mid-cycle between edges
//      -> pc_out does not change until the following rising edge.
//   5. Pull rst low mid-cycle while pc_out = 32'h3333_3333
//      -> pc_out = RESET_PC without waiting for a clock edge. Release rst
//      -> the next edge loads the selected input.
//   6. With FETCH_IN_MISALIGN_EN, pc_sel=1, alu_in=32'h0000_0102
//      -> after the edge pc_out = 32'h0000_0102 and pc_misaligned = 1.
//      Then pc_sel=0, pc_4=32'h0000_0104 -> pc_misaligned = 0.

Source files
------------

// File: rtl/fetch_in_unit.sv
// fetch_in_unit: program-counter register of the fetch stage.
// Each rising clock edge loads either the sequential PC (pc_4) or the ALU redirect target
// (alu_in), chosen by pc_sel. The load is verbatim: no masking, no arithmetic.
// The asynchronous active-low reset forces pc_out to RESET_PC immediately.
// Optional feature macro: FETCH_IN_MISALIGN_EN adds the registered flag pc_misaligned, which
// reports whether the loaded PC has a nonzero low two bits. The PC itself is not corrected.
module fetch_in_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_4,
  input  logic [XLEN-1:0] alu_in,
  input  logic            pc_sel,
`ifdef FETCH_IN_MISALIGN_EN
  output logic            pc_misaligned,
`endif
  output logic [XLEN-1:0] pc_out
);

  logic [XLEN-1:0] pc_d, pc_q;

  // Next-PC select: the redirect target wins when pc_sel is high.
  always_comb begin
    pc_d = pc_4;
    if (pc_sel) begin
      pc_d = alu_in;
    end
  end

  // PC register: loads every cycle, no enable or stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_out = pc_q;

`ifdef FETCH_IN_MISALIGN_EN
  logic misaligned_d, misaligned_q;

  // Misalignment flag tracks the value being loaded so it lines up with pc_out.
  always_comb begin
    misaligned_d = (pc_d[1:0] != 2'b00);
  end

  // Flag register shares the PC's reset and load timing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= misaligned_d;
    end
  end

  assign pc_misaligned = misaligned_q;
`endif

  // An unknown select would load an undefined PC; flag it in simulation.
  pc_sel_known_a : assert property (@(posedge clk) disable iff (!rst) !$isunknown(pc_sel))
    else $error("pc_sel is X/Z at a load edge");

endmodule

// File: tb/tb_fetch_in_unit.sv
// Self-checking bench for fetch_in_unit: directed table, hand-written reset/timing
// sequences and randomized traffic against a simple next-PC reference model.
module tb_fetch_in_unit;

  localparam int unsigned XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_4 = '0;
  logic [31:0] alu_in = '0;
  logic        pc_sel = 1'b0;
  logic [31:0] pc_out;
`ifdef FETCH_IN_MISALIGN_EN
  logic        pc_misaligned;
`endif

  int vectors = 0;
  int miscompares = 0;

  fetch_in_unit #(
    .XLEN    (XLEN),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_4         (pc_4),
    .alu_in       (alu_in),
    .pc_sel       (pc_sel),
`ifdef FETCH_IN_MISALIGN_EN
    .pc_misaligned(pc_misaligned),
`endif
    .pc_out       (pc_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive inputs on the falling edge, then sample just after the rising edge.
  task automatic load(input logic sel, input logic [31:0] alu, input logic [31:0] p4);
    @(negedge clk);
    pc_sel = sel;
    alu_in = alu;
    pc_4   = p4;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        sel;
    logic [31:0] alu;
    logic [31:0] p4;
    logic [31:0] exp_pc;
    logic        exp_mis;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [31:0] exp_pc;
    logic        exp_mis;
    logic [31:0] held;

    tbl[0] = '{1'b1, 32'hAAAA_AAAA, 32'h3333_3333, 32'hAAAA_AAAA, 1'b1};
    tbl[1] = '{1'b0, 32'hAAAA_AAAA, 32'h3333_3333, 32'h3333_3333, 1'b1};
    tbl[2] = '{1'b0, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0000, 1'b0};
    tbl[3] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0010, 32'hFFFF_FFFF, 1'b1};
    tbl[4] = '{1'b1, 32'h0000_0102, 32'h0000_0104, 32'h0000_0102, 1'b1};
    tbl[5] = '{1'b0, 32'h0000_0102, 32'h0000_0104, 32'h0000_0104, 1'b0};
    tbl[6] = '{1'b1, 32'h8000_0000, 32'h1234_5679, 32'h8000_0000, 1'b0};
    tbl[7] = '{1'b0, 32'h8000_0000, 32'h1234_5679, 32'h1234_5679, 1'b1};

    // Reset is visible before the first clock edge.
    #1;
    check("reset_before_edge", pc_out, RESET_PC);
`ifdef FETCH_IN_MISALIGN_EN
    check("reset_mis", {31'b0, pc_misaligned}, 32'h0);
`endif
    @(negedge clk);
    rst = 1'b1;

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      load(tbl[i].sel, tbl[i].alu, tbl[i].p4);
      check($sformatf("table_pc[%0d]", i), pc_out, tbl[i].exp_pc);
`ifdef FETCH_IN_MISALIGN_EN
      check($sformatf("table_mis[%0d]", i), {31'b0, pc_misaligned}, {31'b0, tbl[i].exp_mis});
`endif
    end

    // Redirect held for 100 ns with stable inputs.
    for (int i = 0; i < 10; i++) begin
      load(1'b1, 32'hAAAA_AAAA, 32'h3333_3333);
      check("hold_redirect", pc_out, 32'hAAAA_AAAA);
    end

    // Switch to sequential path.
    load(1'b0, 32'hAAAA_AAAA, 32'h3333_3333);
    check("switch_seq", pc_out, 32'h3333_3333);

    // Mid-cycle input change does not reach pc_out until the next edge.
    @(negedge clk);
    alu_in = 32'h5555_5555;
    pc_4   = 32'h7777_7770;
    pc_sel = 1'b1;
    #2;
    check("midcycle_hold", pc_out, 32'h3333_3333);
    @(posedge clk);
    #1;
    check("midcycle_load", pc_out, 32'h5555_5555);

    // Asynchronous reset mid-cycle, then release and reload.
    load(1'b0, 32'h5555_5555, 32'h3333_3333);
    check("pre_async_rst", pc_out, 32'h3333_3333);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst", pc_out, RESET_PC);
    @(negedge clk);
    check("async_rst_held", pc_out, RESET_PC);
    rst = 1'b1;
    pc_sel = 1'b1;
    alu_in = 32'h0000_0ABC;
    @(posedge clk);
    #1;
    check("post_rst_load", pc_out, 32'h0000_0ABC);

    // Randomized traffic against the reference model, with occasional reset pulses.
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      pc_sel = 1'($urandom_range(0, 1));
      alu_in = $urandom;
      pc_4   = ($urandom_range(0, 3) == 0) ? {$urandom} & 32'hFFFF_FFFC : $urandom;
      exp_pc  = pc_sel ? alu_in : pc_4;
      exp_mis = (exp_pc[1:0] != 2'b00);
      if ($urandom_range(0, 15) == 0) begin
        held = pc_out;
        #1;
        rst = 1'b0;
        #1;
        check("rand_async_rst", pc_out, RESET_PC);
        rst = 1'b1;
      end
      @(posedge clk);
      #1;
      check("rand_pc", pc_out, exp_pc);
`ifdef FETCH_IN_MISALIGN_EN
      check("rand_mis", {31'b0, pc_misaligned}, {31'b0, exp_mis});
`else
      if (exp_mis === 1'bx) $display("unexpected X in model");
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Safety net: never hang.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000 ns");
    $fatal(1, "timeout");
  end

endmodule
